// File: rtl/pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// PwmDutyDecoder (module pwm_duty_decoder)
//
// Purpose:
//   Receive-side counterpart of the PWM generator. Samples an incoming PWM
//   waveform, measures its period and high time in clock cycles, and reports
//   the duty cycle in 10 % steps (0..10). A sequential restoring divider
//   produces round-half-up(10 * high / period), capped at 10. A timeout
//   flags an input that has stopped toggling.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   ena           in   block enable; low = idle (outputs hold)
//   ui_pwm_in     in   asynchronous PWM input
//   uo_duty_step  out  decoded duty 0..10 (x 10 %)
//   uo_period     out  last measured period, cycles (0 after a timeout)
//   uo_high       out  last measured high time, cycles (0 after a timeout)
//   uo_duty_valid out  one-cycle strobe when the outputs update
//   uo_stuck      out  input stuck, sticky until the next good measurement
//
// Parameters:
//   CNT_W    width of the counters and measurement outputs
//   TIMEOUT  cycles without a rising edge before the input is declared
//            stuck; must be <= 2^CNT_W-1 and >= 2
//
// Configuration macro:
//   PWM_DECODE_GLITCH_FILTER_EN  when defined, a level filter after the
//   synchroniser only accepts a new level once it has been stable for 3
//   consecutive cycles, so pulses or notches of 2 cycles or less vanish.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pwm_duty_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             ui_pwm_in,
    output logic [3:0]       uo_duty_step,
    output logic [CNT_W-1:0] uo_period,
    output logic [CNT_W-1:0] uo_high,
    output logic             uo_duty_valid,
    output logic             uo_stuck
);

    // 10 * high + period/2 fits in CNT_W+4 bits for any CNT_W-bit operands.
    localparam int REM_W = CNT_W + 4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT - 1);
    localparam logic [REM_W-1:0] REM_TEN = REM_W'(10);

    localparam logic [1:0] S_WAIT    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_DIVIDE  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic             sync1_q;
    logic             sync2_q;
    logic             pwm_s;
    logic             pwm_s_d_q;
    logic             rise;
    logic             timeout;

    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;

    logic [1:0]       state_q,       state_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d;
    logic [CNT_W-1:0] meas_high_q,   meas_high_d;
    logic [REM_W-1:0] rem_q,         rem_d;
    logic [3:0]       quot_q,        quot_d;
    logic             div_first_q,   div_first_d;

    logic [3:0]       duty_q,        duty_d;
    logic [CNT_W-1:0] out_period_q,  out_period_d;
    logic [CNT_W-1:0] out_high_q,    out_high_d;
    logic             valid_q,       valid_d;
    logic             stuck_q,       stuck_d;

    logic [REM_W-1:0] period_ext;
    logic [REM_W-1:0] rem_init;

    // Two-flop synchroniser; keeps running while disabled so that the
    // level is already settled when the block is re-enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ui_pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_DECODE_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q, filt_d;

    // The filtered level only flips once the synchronised input has shown
    // the same value on three consecutive cycles; both edges are delayed
    // equally so the measured duty is unchanged.
    always_comb begin
        filt_d = filt_q;
        if ({hist_q, sync2_q} == 3'b111) begin
            filt_d = 1'b1;
        end else if ({hist_q, sync2_q} == 3'b000) begin
            filt_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
            filt_q <= filt_d;
        end
    end

    assign pwm_s = filt_q;
`else
    assign pwm_s = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_s_d_q <= 1'b0;
        end else begin
            pwm_s_d_q <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_s_d_q;

    // The timeout event is the single cycle in which the period counter
    // steps onto its saturation value; while it then sits saturated no
    // further event fires, giving one strobe per stuck episode.
    assign timeout = ena && !rise && (period_cnt_q == CNT_PRE);

    // Period / high-time counters. The edge cycle itself counts as cycle 1
    // of the new period (and as a high cycle).
    always_comb begin
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        if (!ena) begin
            period_cnt_d = '0;
            high_cnt_d   = '0;
        end else if (rise) begin
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
        end else begin
            if (period_cnt_q != CNT_MAX) begin
                period_cnt_d = period_cnt_q + CNT_ONE;
            end
            if (pwm_s && (high_cnt_q != CNT_MAX)) begin
                high_cnt_d = high_cnt_q + CNT_ONE;
            end
        end
    end

    assign period_ext = REM_W'(meas_period_q);
    // Adding period/2 before the truncating divide gives round-half-up.
    assign rem_init   = (REM_W'(meas_high_q) * REM_TEN) + REM_W'(meas_period_q >> 1);

    // Measurement FSM and one-quotient-step-per-cycle divider. The output
    // registers are loaded on entry to DONE so they are visible, together
    // with the strobe, during the DONE cycle.
    always_comb begin
        state_d       = state_q;
        meas_period_d = meas_period_q;
        meas_high_d   = meas_high_q;
        rem_d         = rem_q;
        quot_d        = quot_q;
        div_first_d   = div_first_q;
        duty_d        = duty_q;
        out_period_d  = out_period_q;
        out_high_d    = out_high_q;
        valid_d       = 1'b0;
        stuck_d       = stuck_q;

        if (!ena) begin
            state_d = S_WAIT;
        end else if (timeout) begin
            duty_d       = pwm_s ? 4'd10 : 4'd0;
            out_period_d = '0;
            out_high_d   = '0;
            stuck_d      = 1'b1;
            valid_d      = 1'b1;
            state_d      = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT: begin
                    // The period in progress is partial; only arm on an edge.
                    if (rise) begin
                        state_d = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (rise) begin
                        meas_period_d = period_cnt_q;
                        meas_high_d   = high_cnt_q;
                        div_first_d   = 1'b1;
                        state_d       = S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (div_first_q) begin
                        rem_d       = rem_init;
                        quot_d      = 4'd0;
                        div_first_d = 1'b0;
                    end else if ((rem_q >= period_ext) && (quot_q < 4'd10)) begin
                        rem_d  = rem_q - period_ext;
                        quot_d = quot_q + 4'd1;
                    end else begin
                        duty_d       = quot_q;
                        out_period_d = meas_period_q;
                        out_high_d   = meas_high_q;
                        stuck_d      = 1'b0;
                        valid_d      = 1'b1;
                        state_d      = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_MEASURE;
                end
                default: begin
                    state_d = S_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_q  <= '0;
            high_cnt_q    <= '0;
            state_q       <= S_WAIT;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            rem_q         <= '0;
            quot_q        <= 4'd0;
            div_first_q   <= 1'b0;
            duty_q        <= 4'd0;
            out_period_q  <= '0;
            out_high_q    <= '0;
            valid_q       <= 1'b0;
            stuck_q       <= 1'b0;
        end else begin
            period_cnt_q  <= period_cnt_d;
            high_cnt_q    <= high_cnt_d;
            state_q       <= state_d;
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            div_first_q   <= div_first_d;
            duty_q        <= duty_d;
            out_period_q  <= out_period_d;
            out_high_q    <= out_high_d;
            valid_q       <= valid_d;
            stuck_q       <= stuck_d;
        end
    end

    assign uo_duty_step  = duty_q;
    assign uo_period     = out_period_q;
    assign uo_high       = out_high_q;
    assign uo_duty_valid = valid_q;
    assign uo_stuck      = stuck_q;

endmodule
